// File: rtl/stream_downsizer_pkg.sv
// Shared definitions for the stream width-conversion stage: control state
// encoding and small constant helpers used to size and clamp beat indices.
package stream_downsizer_pkg;

  // Two-state control: IDLE waits for a word, SEND walks its beats out.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Ceiling log2, never below 1 so a beat index always has at least one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  // Saturate a beat count to the last legal beat index (RATIO-1). Only
  // reachable when RATIO is not a power of two.
  function automatic int unsigned clamp_idx(input int unsigned cnt,
                                            input int unsigned ratio);
    return (cnt >= ratio) ? (ratio - 1) : cnt;
  endfunction

endpackage

// File: rtl/stream_downsizer.sv
// Wide-to-narrow stream converter: accepts a DW*RATIO word with a beat count
// and emits it LSB slice first as up to RATIO DW-bit beats, flagging the
// final beat of each word. A new word is loaded on the same cycle the last
// beat of the previous one is taken, so full words stream at 1 beat/cycle.
module stream_downsizer
  import stream_downsizer_pkg::*;
#(
  parameter int DW    = 8,
  parameter int RATIO = 4,
  parameter int CW    = clog2(RATIO)
) (
  input  logic                stream_s_valid_i,
  input  logic [DW*RATIO-1:0] stream_s_data_i,
  input  logic [CW-1:0]       stream_s_cnt_i,
  output logic                stream_s_ready_o,
  output logic [DW-1:0]       stream_m_data_o,
  output logic                stream_m_last_o,
  output logic                stream_m_valid_o,
  input  logic                stream_m_ready_i,
  input  logic                clk,
  input  logic                rst_n
);

  state_e                state_q, state_d;
  logic [DW*RATIO-1:0]   hold_q, hold_d;
  logic [CW-1:0]         last_idx_q, last_idx_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         data_q, data_d;

  logic                  s_accept;
  logic                  m_hs;
  logic [CW-1:0]         idx_nxt;

  assign s_accept = stream_s_valid_i && stream_s_ready_o;
  assign m_hs     = stream_m_valid_o && stream_m_ready_i;
  assign idx_nxt  = idx_q + CW'(1);

  // State register: control state, held word, beat pointers and output beat.
  // NOTE: the hold register is reset too, so a reset mid-word leaves nothing
  // stale that could surface as a beat afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      last_idx_q <= '0;
      idx_q      <= '0;
      data_q     <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q    <= state_d;
      hold_q     <= hold_d;
      last_idx_q <= last_idx_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
    end
  end

  // Next-state logic: load on accept, advance on beat handshake, go idle
  // after the last beat unless a new word is taken in the same cycle.
  always_comb begin
    // NOTE: hold-by-default assignments keep this block free of latches.
    state_d    = state_q;
    hold_d     = hold_q;
    last_idx_d = last_idx_q;
    idx_d      = idx_q;
    data_d     = data_q;

    if (s_accept) begin
      // Only possible when idle or while the last beat is being taken.
      state_d    = ST_SEND;
      hold_d     = stream_s_data_i;
      last_idx_d = CW'(clamp_idx(32'(stream_s_cnt_i), RATIO));
      idx_d      = '0;
      data_d     = stream_s_data_i[DW-1:0];
    end else if (m_hs) begin
      if (stream_m_last_o) begin
        state_d = ST_IDLE;
        idx_d   = '0;
        data_d  = '0;
      end else begin
        idx_d  = idx_nxt;
        data_d = hold_q[idx_nxt*DW +: DW];
      end
    end
  end

  // Output logic: beat outputs come straight from registers; input ready
  // opens when idle or when the final beat is leaving this cycle.
  always_comb begin
    stream_m_valid_o = (state_q == ST_SEND);
    stream_m_last_o  = (state_q == ST_SEND) && (idx_q == last_idx_q);
    stream_m_data_o  = data_q;
    stream_s_ready_o = (state_q == ST_IDLE) ||
                       (stream_m_valid_o && stream_m_ready_i && stream_m_last_o);
  end

endmodule

// File: doc/stream_downsizer.md
Name: stream_downsizer

Overview:
- Width-converting stage that sits directly downstream of the dual-clock stream FIFO, in the read clock domain.
- Accepts wide words of DW*RATIO bits on a valid/ready stream slave and emits them as RATIO narrow beats of DW bits on a valid/ready stream master, LSB slice first.
- A per-word beat count allows short words (fewer than RATIO beats). The last emitted beat of each word is flagged so downstream framing logic can see word boundaries.

Parameters:
- DW, 8, output beat width in bits
- RATIO, 4, maximum beats per input word; must be >= 2
- CW, $clog2(RATIO), width of beat count/index; derived, never overridden

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset; assertion is asynchronous, deassertion synchronised externally
- stream_s_data_i  in  DW*RATIO  wide input word; slice k = bits [k*DW +: DW]
- stream_s_cnt_i  in  CW  number of valid beats in word minus 1 (0 = 1 beat, RATIO-1 = full word)
- stream_s_valid_i  in  1  input word valid
- stream_s_ready_o  out  1  input word accepted when valid&&ready
- stream_m_data_o  out  DW  current output beat
- stream_m_last_o  out  1  current beat is the final beat of its word
- stream_m_valid_o  out  1  output beat valid
- stream_m_ready_i  in  1  downstream accepts beat when valid&&ready

Behaviour:
- State: hold register (DW*RATIO), last-index register (CW), beat index (CW), busy flag. Two states: IDLE (busy=0) and SEND (busy=1).
- Reset (rst_n low, async): busy=0, index=0, hold=0, last-index=0. Outputs during and after reset: stream_m_valid_o=0, stream_m_last_o=0, stream_m_data_o=0, stream_s_ready_o=1.
- stream_s_ready_o is combinational: !busy || (stream_m_valid_o && stream_m_ready_i && stream_m_last_o). It never depends on stream_s_valid_i.
- Input accept (valid&&ready):
  - capture data into hold and cnt into last-index; index<=0; busy<=1.
  - First beat appears on the following cycle, so input-to-output latency is 1 cycle.
- Outputs in SEND:
  - stream_m_valid_o = busy.
  - stream_m_data_o = hold slice[index], registered mux.
  - stream_m_last_o = busy && (index == last-index).
- Output handshake when not last: index<=index+1. Hold and valid are stable while stream_m_ready_i is low.
- Output handshake on last beat:
  - with no simultaneous input accept: busy<=0, index<=0.
  - with a simultaneous input accept: load the new word, busy stays 1, index<=0. No bubble cycle is allowed; back-to-back full words sustain 1 beat/cycle.
- stream_s_cnt_i > RATIO-1 cannot occur, since CW bits cover exactly 0..RATIO-1 only when RATIO is a power of 2. For non-power-of-2 RATIO, values >= RATIO are clamped to RATIO-1 at capture.
- Index never wraps past last-index. Data slices above last-index are never emitted.
- A mid-operation reset discards the held word; no partial beats are emitted afterwards.
- stream_m_valid_o, once high, does not drop until the handshake completes (AXI-stream-style stability); data and last are stable with it.

Decomposition:
- Shared stream utilities package/include: clog2 constant function, stream slice-select macro/function (slice k of DW).
- No sub-module needed. Single module with a hold register, counter and 2-state control.

Test Plan:
- Reset: assert rst_n=0 mid-word (index=2) -> valid=0, last=0, data=0, s_ready=1 immediately (async); after release, no stale beats emitted.
- Full word: DW=8, RATIO=4, data=0x44332211, cnt=3, m_ready=1 -> beats 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting 1 cycle after accept; last=1 only on 0x44.
- Short word: data=0xDDCCBBAA, cnt=1 -> beats 0xAA,0xBB; last on 0xBB; s_ready=1 in the same cycle as the 0xBB handshake.
- Back-to-back: words 0x04030201 and 0x08070605, both cnt=3, valid held high -> 8 beats 0x01..0x08 on 8 consecutive cycles with no bubble; second accept coincides with the 0x04 handshake.
- Backpressure: m_ready toggles 1,0,0,1,1,0,1 during a full word -> data/last stable while stalled; exactly 4 beats in order; s_ready low throughout until the last handshake.
- Single-beat words: cnt=0 on 3 consecutive words 0x..A1, 0x..B2, 0x..C3 -> beats 0xA1,0xB2,0xC3 each with last=1, one per cycle.
